mci_bram_responder: RTL and testbench

//  Memory-side responder for the memory controller interface (mci_request_t / mci_response_t).

---
 rtl/memory_controller_interface.sv | 22 ++
 rtl/mci_req_fifo.sv | 55 +++++
 rtl/mci_bram_responder.sv | 195 +++++++++++++++++++
 tb/tb_mci_bram_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/memory_controller_interface.sv
// Memory controller interface package: the request/response records exchanged
// between a cache and its memory-side responder.
package memory_controller_interface;

  localparam int MCI_BLOCK_BITS  = 128;
  localparam int MCI_OFFSET_BITS = 4;
  localparam int MCI_ADDR_BITS   = 32;

  // rw = 1 selects a write of data to the block at addr
  typedef struct packed {
    logic                      valid;
    logic                      rw;
    logic [MCI_ADDR_BITS-1:0]  addr;
    logic [MCI_BLOCK_BITS-1:0] data;
  } mci_request_t;

  typedef struct packed {
    logic                      ready;
    logic [MCI_BLOCK_BITS-1:0] data;
  } mci_response_t;

endpackage

// File: rtl/mci_req_fifo.sv
// Small FIFO of pending mci requests for the BRAM responder.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module mci_req_fifo
  import memory_controller_interface::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  mci_request_t i_data,
  input  logic         i_pop,
  output mci_request_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mci_request_t     r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];

  // Payload storage, written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mci_bram_responder.sv
// Memory-side responder for the mci request/response interface. Serves 128-bit
// block reads/writes from an internal block RAM after a fixed access latency.
// Optional feature macro: MCI_REQ_QUEUE_EN -- requests arriving while busy are
// queued in an mci_req_fifo instead of being dropped.
module mci_bram_responder
  import memory_controller_interface::*;
#(
  parameter int    DEPTH_BLOCKS = 65536,
  parameter int    LATENCY      = 3,
  parameter int    QUEUE_DEPTH  = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  mci_request_t  mem_req,
  output mci_response_t mem_res,
  output logic          busy,
  output logic          err_overrun
);

  localparam int         IDX_BITS = $clog2(DEPTH_BLOCKS);
  localparam int         IDX_LSB  = MCI_OFFSET_BITS;
  localparam int         IDX_MSB  = IDX_LSB + IDX_BITS - 1;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [7:0]                r_count;
  logic                      r_rw;
  logic [IDX_BITS-1:0]       r_idx;
  logic [MCI_BLOCK_BITS-1:0] r_wdata;
  logic [MCI_BLOCK_BITS-1:0] r_res_data;
  logic                      r_err;

  logic                      w_start;
  logic                      w_finish;
  logic                      w_drop;
  mci_request_t              w_start_req;
  logic                      w_unused;

  logic [MCI_BLOCK_BITS-1:0] r_ram [DEPTH_BLOCKS];

`ifdef MCI_REQ_QUEUE_EN
  logic                      w_push;
  logic                      w_pop;
  logic                      w_start_from_q;
  logic                      w_q_full;
  logic                      w_q_empty;
  mci_request_t              w_q_head;

  mci_req_fifo #(
    .DEPTH   (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (mem_req),
    .i_pop   (w_pop),
    .o_head  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  // Queued requests take priority over a request presented directly
  assign w_start_req = w_start_from_q ? w_q_head : mem_req;
  assign busy        = (r_state == ST_WAIT) || !w_q_empty;
  assign w_unused    = ^{w_start_req.valid,
                         w_start_req.addr[MCI_ADDR_BITS-1:IDX_MSB+1],
                         w_start_req.addr[IDX_LSB-1:0],
                         (INIT_FILE != "")};
`else
  assign w_start_req = mem_req;
  assign busy        = (r_state == ST_WAIT);
  assign w_unused    = ^{w_start_req.valid,
                         w_start_req.addr[MCI_ADDR_BITS-1:IDX_MSB+1],
                         w_start_req.addr[IDX_LSB-1:0],
                         (QUEUE_DEPTH > 1),
                         (INIT_FILE != "")};
`endif

  // Next-state logic plus accept/finish/drop strobes
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    w_next_state = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    w_drop       = 1'b0;
`ifdef MCI_REQ_QUEUE_EN
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_start_from_q = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (mem_req.valid) begin
          w_start      = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_count == '0) begin
          w_finish     = 1'b1;
          w_next_state = ST_RESP;
        end
`ifdef MCI_REQ_QUEUE_EN
        w_push = mem_req.valid;
`else
        w_drop = mem_req.valid;
`endif
      end
      ST_RESP: begin
`ifdef MCI_REQ_QUEUE_EN
        if (!w_q_empty) begin
          w_pop          = 1'b1;
          w_start        = 1'b1;
          w_start_from_q = 1'b1;
          w_push         = mem_req.valid;
          w_next_state   = ST_WAIT;
        end else if (mem_req.valid) begin
          w_start      = 1'b1;
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
`else
        if (mem_req.valid) begin
          w_start      = 1'b1;
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
`ifdef MCI_REQ_QUEUE_EN
    // A push into a full queue survives only if the head leaves on the same edge
    w_drop = w_push && w_q_full && !w_pop;
`endif
  end

  // State register, latency counter and latched request fields
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_rw    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_count <= CNT_LOAD;
        r_rw    <= w_start_req.rw;
        r_idx   <= w_start_req.addr[IDX_MSB:IDX_LSB];
        r_wdata <= w_start_req.data;
      end else if (r_state == ST_WAIT && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // RAM write port: commits on the edge entering RESP, never while in reset
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately not reset; a block RAM cannot be cleared in one cycle.
    if (!rst && w_finish && r_rw) r_ram[r_idx] <= r_wdata;
  end

  // Registered response data; holds its value between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_data <= '0;
    end else if (w_finish) begin
      r_res_data <= r_rw ? r_wdata : r_ram[r_idx];
    end
  end

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)         r_err <= 1'b0;
    else if (w_drop) r_err <= 1'b1;
  end

  assign mem_res.ready = (r_state == ST_RESP);
  assign mem_res.data  = r_res_data;
  assign err_overrun   = r_err;

endmodule

// File: tb/tb_mci_bram_responder.sv
// Directed bench for mci_bram_responder: a full-size store and a 4096-block
// store driven by the same requests, so address aliasing is visible.
module tb_mci_bram_responder;
  import memory_controller_interface::*;

  localparam logic [127:0] BLK_A = 128'h0000_0000_0000_0000_0000_0000_ba5e_ba11;
  localparam logic [127:0] BLK_X = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;
  localparam logic [127:0] BLK_Z = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  logic          clk = 1'b0;
  logic          rst;
  mci_request_t  mem_req;
  mci_response_t res_big, res_small;
  logic          busy_big, busy_small;
  logic          err_big, err_small;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;
  int n_rdy;

  always #5 clk = ~clk;

  mci_bram_responder #(
    .DEPTH_BLOCKS (65536),
    .LATENCY      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_res      (res_big),
    .busy         (busy_big),
    .err_overrun  (err_big)
  );

  mci_bram_responder #(
    .DEPTH_BLOCKS (4096),
    .LATENCY      (3)
  ) dut_small (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_res      (res_small),
    .busy         (busy_small),
    .err_overrun  (err_small)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one request for a single cycle; returns at the negedge after the accept edge
  task automatic send(input logic rw, input logic [31:0] addr, input logic [127:0] data);
    mem_req = '{valid: 1'b1, rw: rw, addr: addr, data: data};
    @(negedge clk);
    mem_req = '0;
  endtask

  // Count negedges until ready is seen; -1 if it never comes
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!res_big.ready && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    if (!res_big.ready) cycles = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    mem_req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready",     128'(res_big.ready), 128'(0));
    check("rst_data",      res_big.data,        128'(0));
    check("rst_busy",      128'(busy_big),      128'(0));
    check("rst_err",       128'(err_big),       128'(0));
    check("rst_busy_s",    128'(busy_small),    128'(0));
    check("rst_err_s",     128'(err_small),     128'(0));

    // Read of never-written block: zero data, LATENCY cycles, single-cycle ready
    send(1'b0, 32'h0000_8000, '0);
    wait_ready(cyc);
    check("rd0_latency",   128'(cyc),           128'(3));
    check("rd0_data",      res_big.data,        128'(0));
    @(negedge clk);
    check("rd0_pulse",     128'(res_big.ready), 128'(0));

    // Write then read back the same block
    send(1'b1, 32'h0000_1230, BLK_A);
    wait_ready(cyc);
    check("wr_echo",       res_big.data,        BLK_A);
    @(negedge clk);
    send(1'b0, 32'h0000_1230, '0);
    check("rd_busy",       128'(busy_big),      128'(1));
    wait_ready(cyc);
    check("rdA_data",      res_big.data,        BLK_A);
    check("rdA_data_s",    res_small.data,      BLK_A);

    // Aliasing: 0x18000 hits block 0x800 only in the 4096-block store
    @(negedge clk);
    send(1'b1, 32'h0000_8000, BLK_X);
    wait_ready(cyc);
    @(negedge clk);
    send(1'b0, 32'h0001_8000, '0);
    wait_ready(cyc);
    check("alias_big",     res_big.data,        128'(0));
    check("alias_small",   res_small.data,      BLK_X);

    // Back-to-back: new request presented in the RESP cycle
    @(negedge clk);
    send(1'b0, 32'h0000_1230, '0);
    wait_ready(cyc);
    check("b2b_first",     res_big.data,        BLK_A);
    send(1'b0, 32'h0000_8000, '0);
    wait_ready(cyc);
    check("b2b_latency",   128'(cyc),           128'(3));
    check("b2b_second",    res_big.data,        BLK_X);

    // Second request while in WAIT
    @(negedge clk);
    send(1'b0, 32'h0000_1230, '0);
    mem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_8000, data: '0};
    @(negedge clk);
    mem_req = '0;
`ifdef MCI_REQ_QUEUE_EN
    check("ovr_err_rise",  128'(err_big),       128'(0));
`else
    check("ovr_err_rise",  128'(err_big),       128'(1));
`endif
    wait_ready(cyc);
    check("ovr_first",     res_big.data,        BLK_A);
    n_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_big.ready) n_rdy++;
    end
`ifdef MCI_REQ_QUEUE_EN
    check("ovr_extra_rdy", 128'(n_rdy),         128'(1));
    check("ovr_data",      res_big.data,        BLK_X);
    check("ovr_err_hold",  128'(err_big),       128'(0));
`else
    check("ovr_extra_rdy", 128'(n_rdy),         128'(0));
    check("ovr_data_hold", res_big.data,        BLK_A);
    check("ovr_err_hold",  128'(err_big),       128'(1));
`endif

    // Reset pulsed while a write is pending with counter == 1
    @(negedge clk);
    send(1'b1, 32'h0000_1230, BLK_Z);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",  128'(busy_big),      128'(0));
    check("mid_rst_err",   128'(err_big),       128'(0));
    check("mid_rst_data",  res_big.data,        128'(0));
    n_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_big.ready) n_rdy++;
    end
    check("mid_rst_no_rdy", 128'(n_rdy),        128'(0));
    send(1'b0, 32'h0000_1230, '0);
    wait_ready(cyc);
    check("mid_rst_lat",   128'(cyc),           128'(3));
    check("mid_rst_old",   res_big.data,        BLK_A);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
